// File: rtl/rac_pkg.sv
// Shared types and default field widths for the register-access arbiter.
package rac_pkg;

  localparam int REG_AW    = 7;
  localparam int REG_DW    = 8;
  localparam int REG_CRC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rac_arb_st_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } rac_type_e;

  typedef struct packed {
    rac_type_e              typ;
    logic [REG_AW-1:0]      addr;
    logic [REG_DW-1:0]      wdata;
    logic [REG_CRC_W-1:0]   wcrc;
  } rac_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first pending index at or after rr_ptr, wrapping mod N.
module rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    pend,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] gid,
  output logic            vld
);

  int unsigned idx;

  always_comb begin
    gid = '0;
    vld = 1'b0;
    idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_ptr) + i) % N;
      if (!vld && pend[idx[ID_W-1:0]]) begin
        vld = 1'b1;
        gid = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rac_arb.sv
// Register-access arbiter: round-robin grant of level-held requests onto one bank port.
// Optional bank-ack timeout enabled by defining RAC_ARB_TMO_EN.
module rac_arb #(
  parameter int REQ_NUM   = 2,
  parameter int REG_AW    = rac_pkg::REG_AW,
  parameter int REG_DW    = rac_pkg::REG_DW,
  parameter int REG_CRC_W = rac_pkg::REG_CRC_W,
  parameter int TMO_CYC   = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [REQ_NUM-1:0]           i_req_wr_req,
  input  logic [REQ_NUM-1:0]           i_req_rd_req,
  input  logic [REQ_NUM*REG_AW-1:0]    i_req_addr,
  input  logic [REQ_NUM*REG_DW-1:0]    i_req_wdata,
  input  logic [REQ_NUM*REG_CRC_W-1:0] i_req_wcrc,
  output logic [REQ_NUM-1:0]           o_req_wack,
  output logic [REQ_NUM-1:0]           o_req_rack,
  output logic [REG_DW-1:0]            o_req_data,
  output logic [REG_AW-1:0]            o_req_addr,
  output logic                         o_bank_wr_en,
  output logic                         o_bank_rd_en,
  output logic [REG_AW-1:0]            o_bank_addr,
  output logic [REG_DW-1:0]            o_bank_wdata,
  output logic [REG_CRC_W-1:0]         o_bank_wcrc,
  input  logic                         i_bank_ack,
  input  logic [REG_DW-1:0]            i_bank_rdata,
  output logic                         o_busy,
  output logic                         o_tmo_err
);

  import rac_pkg::*;

  localparam int ID_W = (REQ_NUM > 2) ? $clog2(REQ_NUM) : 1;

  typedef struct packed {
    rac_type_e              typ;
    logic [REG_AW-1:0]      addr;
    logic [REG_DW-1:0]      wdata;
    logic [REG_CRC_W-1:0]   wcrc;
  } cmd_t;

  rac_arb_st_e        state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    pick_gid;
  logic [ID_W-1:0]    ptr_next;
  logic               pick_vld;
  logic [REQ_NUM-1:0] pend;
  logic [REQ_NUM-1:0] gid_onehot;
  cmd_t               cmd;
  cmd_t               pick_cmd;

  assign pend       = i_req_wr_req | i_req_rd_req;
  assign ptr_next   = ID_W'((32'(pick_gid) + 32'd1) % REQ_NUM);
  assign gid_onehot = REQ_NUM'(1) << gid;

  rr_pick #(
    .N    (REQ_NUM),
    .ID_W (ID_W)
  ) u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .gid    (pick_gid),
    .vld    (pick_vld)
  );

  // Write wins when a requester holds both wr and rd.
  always_comb begin
    pick_cmd       = '0;
    pick_cmd.typ   = i_req_wr_req[pick_gid] ? CMD_WR : CMD_RD;
    pick_cmd.addr  = i_req_addr[32'(pick_gid)*REG_AW +: REG_AW];
    pick_cmd.wdata = i_req_wdata[32'(pick_gid)*REG_DW +: REG_DW];
    pick_cmd.wcrc  = i_req_wcrc[32'(pick_gid)*REG_CRC_W +: REG_CRC_W];
  end

  assign o_bank_addr  = cmd.addr;
  assign o_bank_wdata = cmd.wdata;
  assign o_bank_wcrc  = cmd.wcrc;

`ifdef RAC_ARB_TMO_EN
  localparam int TMO_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err;
  logic             tmo_hit;

  assign tmo_hit   = (tmo_cnt + 1'b1) == TMO_W'(TMO_CYC);
  assign o_tmo_err = tmo_err;
`else
  // Never asserts in this build; TMO_CYC stays in the parameter list for compatibility.
  assign o_tmo_err = (TMO_CYC < 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gid          <= '0;
      cmd          <= '0;
      o_req_wack   <= '0;
      o_req_rack   <= '0;
      o_req_data   <= '0;
      o_req_addr   <= '0;
      o_bank_wr_en <= 1'b0;
      o_bank_rd_en <= 1'b0;
      o_busy       <= 1'b0;
`ifdef RAC_ARB_TMO_EN
      tmo_cnt      <= '0;
      tmo_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gid          <= pick_gid;
            cmd          <= pick_cmd;
            rr_ptr       <= ptr_next;
            o_bank_wr_en <= (pick_cmd.typ == CMD_WR);
            o_bank_rd_en <= (pick_cmd.typ == CMD_RD);
            o_busy       <= 1'b1;
            state        <= WAIT;
`ifdef RAC_ARB_TMO_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        WAIT: begin
          if (i_bank_ack) begin
            o_bank_wr_en <= 1'b0;
            o_bank_rd_en <= 1'b0;
            o_req_addr   <= cmd.addr;
            o_req_data   <= (cmd.typ == CMD_WR) ? cmd.wdata : i_bank_rdata;
            o_req_wack   <= (cmd.typ == CMD_WR) ? gid_onehot : '0;
            o_req_rack   <= (cmd.typ == CMD_RD) ? gid_onehot : '0;
            state        <= RESP;
`ifdef RAC_ARB_TMO_EN
          end else if (tmo_hit) begin
            o_bank_wr_en <= 1'b0;
            o_bank_rd_en <= 1'b0;
            o_req_addr   <= cmd.addr;
            o_req_data   <= '0;
            o_req_wack   <= (cmd.typ == CMD_WR) ? gid_onehot : '0;
            o_req_rack   <= (cmd.typ == CMD_RD) ? gid_onehot : '0;
            tmo_err      <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt      <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          o_req_wack <= '0;
          o_req_rack <= '0;
          o_busy     <= 1'b0;
          state      <= IDLE;
`ifdef RAC_ARB_TMO_EN
          tmo_err    <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rac_arb.md
# rac_arb

Register-access arbiter between several register-access requesters (SPI slave, one-wire slave, internal test port) and the single register bank port. It accepts level-held write/read requests, grants one at a time with round-robin fairness, drives the bank through a req/ack handshake, and returns a one-cycle wack/rack with response data to the granted requester only. It sits between the interface slaves and the register access controller.

## Interface
- REQ_NUM, 2, number of requesters (2..4); ID_W = max(1, $clog2(REQ_NUM))
- REG_AW, 7, register address width
- REG_DW, 8, register data width
- REG_CRC_W, 8, write CRC width
- TMO_CYC, 255, bank-ack timeout in i_clk cycles (used only with RAC_ARB_TMO_EN)
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-high
- i_req_wr_req  in  REQ_NUM  per-requester write request, level, held until its wack
- i_req_rd_req  in  REQ_NUM  per-requester read request, level, held until its rack
- i_req_addr  in  REQ_NUM*REG_AW  packed addresses; requester n at [n*REG_AW +: REG_AW]
- i_req_wdata  in  REQ_NUM*REG_DW  packed write data
- i_req_wcrc  in  REQ_NUM*REG_CRC_W  packed write CRC
- o_req_wack  out  REQ_NUM  one-cycle write ack, granted bit only
- o_req_rack  out  REQ_NUM  one-cycle read ack, granted bit only
- o_req_data  out  REG_DW  response data, valid in the ack cycle
- o_req_addr  out  REG_AW  response address, valid in the ack cycle
- o_bank_wr_en  out  1  bank write request, level until i_bank_ack
- o_bank_rd_en  out  1  bank read request, level until i_bank_ack
- o_bank_addr / o_bank_wdata / o_bank_wcrc  out  REG_AW / REG_DW / REG_CRC_W  latched command fields
- i_bank_ack  in  1  bank completion; sampled only in WAIT
- i_bank_rdata  in  REG_DW  read data, valid with i_bank_ack
- o_busy  out  1  high in any state other than IDLE
- o_tmo_err  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, WAIT, RESP. All outputs registered; reset value of every output is 0. Internal: rr_ptr=0, state=IDLE.
- IDLE: pend[n] = wr_req[n] | rd_req[n]. If any pend, grant the first pending index scanning rr_ptr, rr_ptr+1, … mod REQ_NUM. Latch gid, type (wr_req has priority if both are set), addr, wdata, wcrc. Set rr_ptr = (gid+1) mod REQ_NUM. Go to WAIT.
- WAIT: o_bank_wr_en or o_bank_rd_en is held with latched fields. On i_bank_ack: capture rdata (read) or keep wdata (write), deassert en, go to RESP.
- RESP: exactly one cycle. o_req_wack[gid] or o_req_rack[gid] = 1, o_req_addr = latched addr, o_req_data = rdata (read) / wdata (write). Then go to IDLE.
- Requesters must drop their req at the clock edge that ends their ack cycle. IDLE in the next cycle re-arbitrates, so there are no back-to-back duplicates.
- If a requester deasserts req after grant, the transaction still completes and the ack is still issued.
- New requests during WAIT/RESP wait in pend. i_bank_ack outside WAIT is ignored.
- o_req_data/o_req_addr hold their last value outside RESP.

## Timing
- Req visible cycle 0 → o_bank_*_en high cycle 1. Ack in cycle k≥1 → requester ack in cycle k+1, next grant earliest in cycle k+2.
- Minimum transaction time is 3 cycles per access. Two continuously pending requesters alternate.
- i_rst asserted mid-transaction: immediately IDLE, en/ack low, rr_ptr=0; the pending access is lost and the requester must re-request.

## Configuration
- RAC_ARB_TMO_EN defined: an 8+ bit counter clears on entering WAIT and increments in WAIT. When it reaches TMO_CYC with no ack:
  - drop en, go to RESP, issue the normal ack with o_req_data=0;
  - pulse o_tmo_err for one cycle, coincident with the ack.
- An ack and the timeout in the same cycle: the ack wins, no error.
- RAC_ARB_TMO_EN undefined: WAIT waits indefinitely; o_tmo_err tied 0; no counter logic.

## Structure
- Package rac_pkg:
  - state enum rac_arb_st_e {IDLE, WAIT, RESP};
  - typedef rac_cmd_t {type, addr, wdata, wcrc};
  - REG_AW/REG_DW/REG_CRC_W defaults shared with com_param.
- Sub-module rr_pick: combinational round-robin index select (pend, rr_ptr → gid, vld), reusable by other arbiters.

## Test plan
- Single read: req 0 rd addr 0x12, bank acks cycle 1 with 0xA5 → rack[0] in cycle 2, o_req_data=0xA5, o_req_addr=0x12, rack[1] stays 0.
- Contention: both requesters raise wr in the same cycle from reset → requester 0 granted first, requester 1 next; with both held continuously, grants alternate 0,1,0,1.
- Bank stall: ack delayed 10 cycles → en held 10 cycles with stable addr/wdata/wcrc, wack exactly one cycle, o_busy high throughout.
- Both wr and rd set on requester 1, wdata 0x3C → bank sees wr_en only; wack[1] with o_req_data=0x3C.
- RAC_ARB_TMO_EN, TMO_CYC=4, no bank ack → en drops and o_tmo_err + rack pulse together with data 0; rerun without the macro → no ack ever, o_tmo_err stays 0.
- Assert i_rst during WAIT → all outputs 0 asynchronously. After release, a fresh request from requester 1 with requester 0 idle is granted normally.
